hamming_dec_engine: RTL and testbench



---
 rtl/hamming_dec_engine_pkg.sv | 40 ++++
 rtl/hamming15_correct.sv | 33 +++
 rtl/hamming_dec_engine.sv | 150 +++++++++++++++
 tb/tb_hamming_dec_engine.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_dec_engine_pkg.sv
// ------------------------------------------------------------------
// hamming_pkg : shared types and helpers for the Hamming(15,11) decoder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package hamming_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_LO  = 3'd1,
    RD_HI  = 3'd2,
    CAP_HI = 3'd3,
    WR_LO  = 3'd4,
    WR_HI  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [3:0] c_PAR_P1 = 4'd1;
  localparam logic [3:0] c_PAR_P2 = 4'd2;
  localparam logic [3:0] c_PAR_P4 = 4'd4;
  localparam logic [3:0] c_PAR_P8 = 4'd8;

  function automatic logic is_parity_pos(input logic [3:0] p);
    return (p == c_PAR_P1) || (p == c_PAR_P2) || (p == c_PAR_P4) || (p == c_PAR_P8);
  endfunction

  // Syndrome is the XOR of the positions of every set bit.
  function automatic logic [3:0] syndrome15(input logic [15:1] code);
    logic [3:0] s;
    s = 4'd0;
    for (int p = 1; p <= 15; p++) begin
      if (code[p]) s = s ^ 4'(p);
    end
    return s;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hamming15_correct.sv
// ------------------------------------------------------------------
// hamming15_correct : combinational single-error correct + data extract
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hamming15_correct
  import hamming_pkg::*;
(
  input  logic [15:1] i_code,
  output logic [11:1] o_data,
  output logic [3:0]  o_syn,
  output logic        o_err
);

  logic [15:1] w_fixed;

  assign o_syn = syndrome15(i_code);
  assign o_err = |o_syn;

  // Data bits are packed by shifting in from the top, lowest position first.
  always_comb begin
    w_fixed = i_code;
    o_data  = '0;
    for (int p = 1; p <= 15; p++) begin
      if (o_syn == 4'(p)) w_fixed[p] = ~i_code[p];
      if (!is_parity_pos(4'(p))) o_data = {w_fixed[p], o_data[11:2]};
    end
  end

endmodule

`default_nettype wire

// File: rtl/hamming_dec_engine.sv
// ------------------------------------------------------------------
// hamming_dec_engine : memory-to-memory Hamming(15,11) decode engine
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hamming_dec_engine
  import hamming_pkg::*;
#(
  parameter int SRC_BASE = 64,
  parameter int DST_BASE = 94,
  parameter int NUM_MSG  = 15,
  parameter int AW       = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  output logic          o_ack,
  output logic          o_busy,
  output logic [AW-1:0] o_mem_addr,
  output logic          o_mem_rd_en,
  input  logic [7:0]    i_mem_rdata,
  output logic          o_mem_wr_en,
  output logic [7:0]    o_mem_wdata,
  output logic [3:0]    o_err_cnt
);

  localparam int c_IW = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1;
  localparam logic [c_IW-1:0] c_LAST = c_IW'(NUM_MSG - 1);

  state_t          r_state;
  logic [c_IW-1:0] r_idx;
  logic            r_req_d;
  logic [7:0]      r_lo;
  logic [2:0]      r_dhi;
  logic            r_err;
  logic            r_ack;
  logic            r_busy;
  logic [AW-1:0]   r_addr;
  logic            r_rd_en;
  logic            r_wr_en;
  logic [7:0]      r_wdata;
  logic [3:0]      r_err_cnt;

  logic [15:1] w_code;
  logic [11:1] w_data;
  logic [3:0]  w_unused_syn;
  logic        w_err;
  logic        w_unused_b7;

  // The high byte is consumed straight off the read port in CAP_HI.
  assign w_code      = {i_mem_rdata[6:0], r_lo};
  assign w_unused_b7 = i_mem_rdata[7];

  hamming15_correct u_correct (
    .i_code (w_code),
    .o_data (w_data),
    .o_syn  (w_unused_syn),
    .o_err  (w_err)
  );

  function automatic logic [AW-1:0] f_addr(input int base, input logic [c_IW-1:0] idx,
                                           input logic odd);
    return AW'(base + 2 * int'(idx) + int'(odd));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_req_d   <= 1'b0;
      r_lo      <= '0;
      r_dhi     <= '0;
      r_err     <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_addr    <= '0;
      r_rd_en   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wdata   <= '0;
      r_err_cnt <= '0;
    end else begin
      r_req_d <= i_req;
      r_ack   <= 1'b0;
      r_rd_en <= 1'b0;
      r_wr_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_req && !r_req_d) begin
            r_state   <= RD_LO;
            r_idx     <= '0;
            r_err_cnt <= '0;
            r_busy    <= 1'b1;
            r_rd_en   <= 1'b1;
            r_addr    <= f_addr(SRC_BASE, '0, 1'b0);
          end
        end
        RD_LO: begin
          r_state <= RD_HI;
          r_rd_en <= 1'b1;
          r_addr  <= f_addr(SRC_BASE, r_idx, 1'b1);
        end
        RD_HI: begin
          r_lo    <= i_mem_rdata;
          r_state <= CAP_HI;
        end
        CAP_HI: begin
          r_dhi   <= w_data[11:9];
          r_err   <= w_err;
          r_wr_en <= 1'b1;
          r_addr  <= f_addr(DST_BASE, r_idx, 1'b0);
          r_wdata <= w_data[8:1];
          r_state <= WR_LO;
        end
        WR_LO: begin
          if (r_err && (r_err_cnt != 4'hF)) r_err_cnt <= r_err_cnt + 4'd1;
          r_wr_en <= 1'b1;
          r_addr  <= f_addr(DST_BASE, r_idx, 1'b1);
          r_wdata <= {5'b0, r_dhi};
          r_state <= WR_HI;
        end
        WR_HI: begin
          if (r_idx == c_LAST) begin
            r_state <= DONE;
            r_ack   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
            r_idx   <= r_idx + 1'b1;
            r_state <= RD_LO;
            r_rd_en <= 1'b1;
            r_addr  <= f_addr(SRC_BASE, r_idx + 1'b1, 1'b0);
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_ack       = r_ack;
  assign o_busy      = r_busy;
  assign o_mem_addr  = r_addr;
  assign o_mem_rd_en = r_rd_en;
  assign o_mem_wr_en = r_wr_en;
  assign o_mem_wdata = r_wdata;
  assign o_err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hamming_dec_engine.sv
// ------------------------------------------------------------------
// tb_hamming_dec_engine : randomized self-checking bench for the decoder
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_hamming_dec_engine;

  localparam int SRC = 64;
  localparam int DST = 94;
  localparam int NUM = 15;

  logic       clk = 1'b0;
  logic       rst_n, req, ack, busy, rd_en, wr_en;
  logic [7:0] addr, rdata, wdata;
  logic [3:0] err_cnt;

  logic [7:0] mem [256];
  logic       tb_we;
  logic [7:0] tb_a, tb_d;

  logic [15:0] exp_q [$];
  logic [10:0] msg  [NUM];
  int          fpos [NUM];
  logic        nz   [NUM];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hamming_dec_engine #(.SRC_BASE(SRC), .DST_BASE(DST), .NUM_MSG(NUM), .AW(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req       (req),
    .o_ack       (ack),
    .o_busy      (busy),
    .o_mem_addr  (addr),
    .o_mem_rd_en (rd_en),
    .i_mem_rdata (rdata),
    .o_mem_wr_en (wr_en),
    .o_mem_wdata (wdata),
    .o_err_cnt   (err_cnt)
  );

  always @(posedge clk) begin
    if (rd_en) rdata <= mem[addr];
    if (wr_en) mem[addr] <= wdata;
    if (tb_we) mem[tb_a] <= tb_d;
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every DUT write is checked in order against the expected write stream.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) chk("extra_write", int'({addr, wdata}), -1);
      else begin
        chk("write", int'({addr, wdata}), int'(exp_q[0]));
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic logic [15:0] encode(input logic [10:0] d);
    logic [15:0] c;
    int k, s;
    c = '0; k = 0; s = 0;
    for (int p = 1; p <= 15; p++) begin
      if (p != 1 && p != 2 && p != 4 && p != 8) begin
        c[p] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 15; p++) if (c[p]) s = s ^ p;
    for (int b = 0; b < 4; b++) if (s[b]) c[1 << b] = 1'b1;
    return c;
  endfunction

  function automatic int exp_errs();
    int c;
    c = 0;
    for (int i = 0; i < NUM; i++) if (fpos[i] != 0) c++;
    return (c > 15) ? 15 : c;
  endfunction

  task automatic poke(input int a, input logic [7:0] d);
    tb_we = 1'b1; tb_a = 8'(a); tb_d = d;
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic set_rand(input int mode);
    for (int i = 0; i < NUM; i++) begin
      msg[i]  = 11'($urandom_range(0, 2047));
      fpos[i] = (mode == 2) ? int'($urandom_range(0, 15)) : 0;
      nz[i]   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  endtask

  task automatic load_src();
    logic [15:0] c;
    for (int i = 0; i < NUM; i++) begin
      c = encode(msg[i]);
      if (fpos[i] != 0) c[fpos[i]] = ~c[fpos[i]];
      poke(SRC + 2 * i, c[8:1]);
      poke(SRC + 2 * i + 1, {nz[i], c[15:9]});
    end
    for (int j = 0; j < 2 * NUM; j++) poke(DST + j, 8'hEE);
  endtask

  task automatic push_exp(input int nwords);
    exp_q.delete();
    for (int i = 0; i < nwords; i++) begin
      exp_q.push_back({8'(DST + 2 * i), msg[i][7:0]});
      exp_q.push_back({8'(DST + 2 * i + 1), 5'b0, msg[i][10:8]});
    end
  endtask

  task automatic check_dst(input int nwords);
    for (int i = 0; i < nwords; i++) begin
      chk("dst_lo", int'(mem[DST + 2 * i]), int'(msg[i][7:0]));
      chk("dst_hi", int'(mem[DST + 2 * i + 1]), int'({5'b0, msg[i][10:8]}));
    end
  endtask

  task automatic do_run(input bit mid_pulse);
    int k;
    bit got;
    push_exp(NUM);
    @(negedge clk); req = 1'b1;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    got = 1'b0;
    for (k = 1; k <= 200; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (mid_pulse) req = (k == 20);
      if (ack) begin
        got = 1'b1;
        break;
      end
    end
    req = 1'b0;
    chk("ack_latency", got ? k : -1, NUM * 5);
    chk("err_cnt", int'(err_cnt), exp_errs());
    chk("busy_at_ack", int'(busy), 0);
    chk("writes_left", exp_q.size(), 0);
    @(negedge clk);
    chk("ack_pulse", int'(ack), 0);
    check_dst(NUM);
  endtask

  task automatic held_run();
    int acks;
    push_exp(NUM);
    acks = 0;
    @(negedge clk); req = 1'b1;
    repeat (200) begin
      @(posedge clk);
      @(negedge clk);
      if (ack) acks++;
    end
    req = 1'b0;
    chk("held_req_acks", acks, 1);
    chk("held_err_cnt", int'(err_cnt), exp_errs());
    chk("held_writes_left", exp_q.size(), 0);
    check_dst(NUM);
  endtask

  task automatic reset_run();
    push_exp(7);
    @(negedge clk); req = 1'b1;
    @(posedge clk);
    @(negedge clk); req = 1'b0;
    repeat (38) @(posedge clk);
    #1;
    chk("w7_wr_lo_en", int'(wr_en), 1);
    chk("w7_wr_lo_addr", int'(addr), DST + 14);
    rst_n = 1'b0;
    #1;
    chk("rst_ack", int'(ack), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rst_writes_left", exp_q.size(), 0);
    check_dst(7);
    chk("rst_no_w7", int'(mem[DST + 14]), 8'hEE);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 1'b0; tb_we = 1'b0; tb_a = '0; tb_d = '0;
    repeat (3) @(negedge clk);
    chk("reset_ack", int'(ack), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_rd_en", int'(rd_en), 0);
    chk("reset_wr_en", int'(wr_en), 0);
    chk("reset_addr", int'(addr), 0);
    chk("reset_wdata", int'(wdata), 0);
    chk("reset_err_cnt", int'(err_cnt), 0);
    rst_n = 1'b1;

    chk("pin_encode", int'(encode(11'h5A3)), 32'hB42C);

    set_rand(0); load_src(); do_run(1'b0);

    set_rand(0);
    for (int i = 0; i < 3; i++) msg[i] = 11'h5A3;
    fpos[0] = 15; fpos[1] = 8; fpos[2] = 3;
    load_src(); do_run(1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("pin_5a3_lo", int'(mem[DST + 2 * i]), 8'hA3);
      chk("pin_5a3_hi", int'(mem[DST + 2 * i + 1]), 8'h05);
    end
    chk("pin_err3", int'(err_cnt), 3);

    set_rand(1); load_src(); do_run(1'b1);
    chk("pin_bit7_err0", int'(err_cnt), 0);

    set_rand(2); load_src(); do_run(1'b0);
    set_rand(2); load_src(); do_run(1'b0);

    set_rand(2); load_src(); held_run();

    set_rand(2); load_src(); reset_run();
    set_rand(2); load_src(); do_run(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
